dac_stream_ctrl: RTL and testbench

Playback counterpart of the SAR ADC sequencer. It buffers 10-bit samples written by the bus wrapper in an internal FIFO and presents them to an external 10-bit DAC at a programmable sample rate. Each new code is qualified with a one-cycle load strobe. The block reports FIFO level, threshold, underflow and overflow status for interrupt generation in the wrapper.

---
 rtl/dac_stream_pkg.sv | 13 +
 rtl/dac_stream_fifo.sv | 71 +++++++
 rtl/dac_stream_ctrl.sv | 124 ++++++++++++
 tb/tb_dac_stream_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_stream_pkg.sv
// Shared FSM encoding and constants for the DAC playback streamer.
package dac_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam int DAC_DW = 10;
  localparam logic [DAC_DW-1:0] DAC_MIDSCALE = 10'h200;

endpackage

// File: rtl/dac_stream_fifo.sv
// Sample FIFO for the DAC streamer: storage, pointers, level and registered flags.
// flush clears pointers and level and overrides any same-cycle push or pop.
module dac_stream_fifo
  import dac_stream_pkg::*;
#(
  parameter int DW      = DAC_DW,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [DW-1:0]      wdata,
  output logic [DW-1:0]      rdata,
  output logic [FIFO_AW:0]   level,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic               do_push;
  logic               do_pop;
  logic [FIFO_AW:0]   level_nxt;

  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rptr];

  always_comb begin
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == DEPTH_L);
      empty <= (level_nxt == '0);
    end
  end

  // Storage needs no reset; the level and flags gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/dac_stream_ctrl.sv
// DAC playback controller: prefill/run sequencing, sample-rate timing and DAC load strobe.
// Build option DAC_STREAM_MIDSCALE_ON_UNDERFLOW_EN parks the DAC at midscale on underflow.
module dac_stream_ctrl
  import dac_stream_pkg::*;
#(
  parameter int DW           = DAC_DW,
  parameter int FIFO_AW      = 4,
  parameter int CLKDIV_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    flush,
  input  logic [CLKDIV_WIDTH-1:0] clkdiv,
  input  logic [CLKDIV_WIDTH-1:0] sample_div,
  input  logic                    wr,
  input  logic [DW-1:0]           wdata,
  input  logic [FIFO_AW:0]        fifo_threshold,
  output logic [FIFO_AW:0]        fifo_level,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    fifo_below,
  output logic                    underflow,
  output logic                    overflow,
  input  logic                    status_clr,
  output logic                    running,
  output logic [DW-1:0]           dac_data,
  output logic                    dac_load
);

`ifdef DAC_STREAM_MIDSCALE_ON_UNDERFLOW_EN
  localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};
`endif

  state_t                  state;
  logic [CLKDIV_WIDTH-1:0] pctr;
  logic [CLKDIV_WIDTH-1:0] sctr;
  logic                    tick;
  logic                    sample_tick;
  logic                    pop;
  logic [DW-1:0]           rdata;

  assign running     = (state == ST_RUN);
  assign tick        = running && (pctr == clkdiv);
  assign sample_tick = tick && (sctr == sample_div);
  assign pop         = sample_tick & ~fifo_empty;
  assign fifo_below  = (fifo_level < fifo_threshold);

  dac_stream_fifo #(
    .DW      (DW),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (wr),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // state   | meaning
  // IDLE    | stopped; FIFO and dac_data retained
  // PREFILL | waiting for level >= fifo_threshold
  // RUN     | timers active, one pop per sample tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (!en) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state <= ST_PREFILL;
        ST_PREFILL: if (fifo_level >= fifo_threshold) state <= ST_RUN;
        ST_RUN:     state <= ST_RUN;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Counters sit at zero outside RUN, so every RUN entry starts a fresh period.
  always_ff @(posedge clk) begin
    if (rst || !running) begin
      pctr <= '0;
      sctr <= '0;
    end else if (tick) begin
      pctr <= '0;
      sctr <= (sctr == sample_div) ? '0 : sctr + 1'b1;
    end else begin
      pctr <= pctr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dac_data  <= '0;
      dac_load  <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      dac_load <= 1'b0;
      if (pop && !flush) begin
        dac_data <= rdata;
        dac_load <= 1'b1;
      end
`ifdef DAC_STREAM_MIDSCALE_ON_UNDERFLOW_EN
      else if (sample_tick && fifo_empty) begin
        dac_data <= MIDSCALE;
        dac_load <= 1'b1;
      end
`endif

      if (sample_tick && fifo_empty) underflow <= 1'b1;
      else if (status_clr)           underflow <= 1'b0;

      if (wr && fifo_full)   overflow <= 1'b1;
      else if (status_clr)   overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// Randomized bench for dac_stream_ctrl against a queue/period-based playback model.
module tb_dac_stream_ctrl;

  localparam int DW = 10;
  localparam int AW = 4;
  localparam int CW = 8;
  localparam int DEPTH = 16;
  localparam int M_IDLE = 0, M_PREFILL = 1, M_RUN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] clkdiv = '0;
  logic [CW-1:0] sample_div = '0;
  logic          wr = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [AW:0]   fifo_threshold = '0;
  logic          status_clr = 1'b0;
  logic [AW:0]   fifo_level;
  logic          fifo_full, fifo_empty, fifo_below;
  logic          underflow, overflow, running;
  logic [DW-1:0] dac_data;
  logic          dac_load;

  int checks = 0;
  int failures = 0;

  dac_stream_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .clkdiv(clkdiv),
    .sample_div(sample_div), .wr(wr), .wdata(wdata),
    .fifo_threshold(fifo_threshold), .fifo_level(fifo_level),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_below(fifo_below),
    .underflow(underflow), .overflow(overflow), .status_clr(status_clr),
    .running(running), .dac_data(dac_data), .dac_load(dac_load)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue for the FIFO and a cycle count since RUN entry
  logic [DW-1:0] q[$];
  int            m_mode = M_IDLE;
  int            m_rc = 0;
  logic [DW-1:0] m_dac = '0;
  bit            m_load = 0, m_uf = 0, m_of = 0;
  bit            model_valid = 0;

  always @(posedge clk) begin
    int  p, lvl;
    bit  st, emp, ful;
    if (rst) begin
      q.delete();
      m_mode = M_IDLE; m_rc = 0; m_dac = '0;
      m_load = 0; m_uf = 0; m_of = 0;
      model_valid = 1;
    end else if (model_valid) begin
      p   = (int'(clkdiv) + 1) * (int'(sample_div) + 1);
      lvl = q.size();
      emp = (lvl == 0);
      ful = (lvl == DEPTH);
      st  = (m_mode == M_RUN) && (((m_rc + 1) % p) == 0);
      m_load = 0;
      if (st && !emp && !flush) begin
        m_dac = q[0];
        m_load = 1;
      end
`ifdef DAC_STREAM_MIDSCALE_ON_UNDERFLOW_EN
      if (st && emp) begin
        m_dac = 10'h200;
        m_load = 1;
      end
`endif
      if (st && emp) m_uf = 1; else if (status_clr) m_uf = 0;
      if (wr && ful) m_of = 1; else if (status_clr) m_of = 0;
      if (flush) q.delete();
      else begin
        if (st && !emp) void'(q.pop_front());
        if (wr && !ful) q.push_back(wdata);
      end
      if (!en) begin
        m_mode = M_IDLE; m_rc = 0;
      end else if (m_mode == M_IDLE) m_mode = M_PREFILL;
      else if (m_mode == M_PREFILL) begin
        if (lvl >= int'(fifo_threshold)) begin m_mode = M_RUN; m_rc = 0; end
      end else m_rc++;
    end
  end

  int cyc = 0;
  int run_rise_cyc = 0;
  bit prev_run = 0;
  int load_cyc[$];
  logic [DW-1:0] load_dat[$];

  always @(negedge clk) begin
    if (model_valid) begin
      cyc++;
      checks++;
      if (fifo_level !== (AW+1)'(q.size()) || fifo_full !== (q.size() == DEPTH) ||
          fifo_empty !== (q.size() == 0) || fifo_below !== (q.size() < int'(fifo_threshold)) ||
          underflow !== m_uf || overflow !== m_of || running !== (m_mode == M_RUN) ||
          dac_data !== m_dac || dac_load !== m_load) begin
        failures++;
        $display("FAIL model cyc=%0d act lvl=%0d full=%b emp=%b below=%b uf=%b of=%b run=%b dac=%h load=%b exp lvl=%0d uf=%b of=%b run=%b dac=%h load=%b",
                 cyc, fifo_level, fifo_full, fifo_empty, fifo_below, underflow, overflow,
                 running, dac_data, dac_load, q.size(), m_uf, m_of, m_mode == M_RUN, m_dac, m_load);
      end
      if (running && !prev_run) run_rise_cyc = cyc;
      prev_run = running;
      if (dac_load) begin
        load_cyc.push_back(cyc);
        load_dat.push_back(dac_data);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1; en = 0; wr = 0; flush = 0; status_clr = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr = 1; wdata = d; step(); wr = 0;
  endtask

  task automatic wait_running(input int bound);
    int n = 0;
    while (running !== 1'b1 && n < bound) begin step(); n++; end
    check("wait_running", 32'(running), 1);
  endtask

  initial begin
    int n, nl;
    // test 1: basic playback and underflow
    clkdiv = 3; sample_div = 1; fifo_threshold = 2;
    do_reset();
    check("rst_level", 32'(fifo_level), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_below", 32'(fifo_below), 1);
    check("rst_dac", 32'(dac_data), 0);
    check("rst_running", 32'(running), 0);
    for (int i = 1; i <= 3; i++) push(DW'(i));
    check("t1_level3", 32'(fifo_level), 3);
    load_cyc.delete(); load_dat.delete();
    en = 1;
    wait_running(10);
    repeat (40) step();
    check("t1_nloads", 32'(load_dat.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < load_dat.size()) begin
        check("t1_load_data", 32'(load_dat[i]), 32'(i + 1));
        check("t1_load_time", 32'(load_cyc[i] - run_rise_cyc), 32'(8 * (i + 1)));
      end
    end
    check("t1_underflow", 32'(underflow), 1);
    check("t1_dac_hold", 32'(dac_data), 3);

    // test 2: overflow
    do_reset();
    for (int i = 0; i < 17; i++) push(DW'(i));
    check("t2_level", 32'(fifo_level), 16);
    check("t2_full", 32'(fifo_full), 1);
    check("t2_overflow", 32'(overflow), 1);
    status_clr = 1; step(); status_clr = 0;
    check("t2_ovf_clr", 32'(overflow), 0);
    check("t2_level_kept", 32'(fifo_level), 16);

    // test 3: sample every clock with steady level 1
    clkdiv = 0; sample_div = 0; fifo_threshold = 0;
    do_reset();
    push(10'h3a5);
    en = 1; step(); step();
    wr = 1;
    for (int i = 0; i < 16; i++) begin
      wdata = DW'($urandom);
      step();
      check("t3_load", 32'(dac_load), 1);
      check("t3_level", 32'(fifo_level), 1);
    end
    en = 0; wr = 0; step(); step();
    check("t3_no_underflow", 32'(underflow), 0);

    // test 4: en drop mid-RUN, then re-enable
    clkdiv = 1; sample_div = 1; fifo_threshold = 3;
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'(10'h100 + i));
    en = 1;
    n = 0;
    while (fifo_level != 5 && n < 200) begin step(); n++; end
    check("t4_reach5", 32'(fifo_level), 5);
    en = 0; step();
    check("t4_stopped", 32'(running), 0);
    nl = load_dat.size();
    repeat (10) step();
    check("t4_level_kept", 32'(fifo_level), 5);
    check("t4_no_loads", 32'(load_dat.size()), 32'(nl));
    en = 1;
    n = 0;
    while (load_dat.size() == nl && n < 50) begin step(); n++; end
    check("t4_reload", 32'(load_dat.size() > nl), 1);
    if (load_dat.size() > nl) check("t4_first_period", 32'(load_cyc[nl] - run_rise_cyc), 4);
    check("t4_next_word", 32'(dac_data), 32'h103);

    // test 5/6: flush together with wr and a sample tick
    clkdiv = 0; sample_div = 0; fifo_threshold = 4;
    do_reset();
    for (int i = 0; i < 4; i++) push(DW'(10'h050 + i));
    en = 1;
    wait_running(10);
    flush = 1; wr = 1; wdata = 10'h155;
    step();
    check("t5_level0", 32'(fifo_level), 0);
    check("t5_empty", 32'(fifo_empty), 1);
    check("t5_no_load", 32'(dac_load), 0);
    check("t5_no_uf", 32'(underflow), 0);
    status_clr = 1;
    step();
    flush = 0; wr = 0; status_clr = 0;
    check("t5_uf_empty", 32'(underflow), 1);
    check("t5_level_still0", 32'(fifo_level), 0);
`ifdef DAC_STREAM_MIDSCALE_ON_UNDERFLOW_EN
    check("t6_mid_load", 32'(dac_load), 1);
    check("t6_mid_data", 32'(dac_data), 32'h200);
`else
    check("t5_hold_load", 32'(dac_load), 0);
`endif

    // randomized segments
    for (int seg = 0; seg < 15; seg++) begin
      int wr_pct;
      en = 0; wr = 0; flush = 0; status_clr = 0; rst = 0;
      step(); step();
      clkdiv = CW'($urandom_range(0, 3));
      sample_div = CW'($urandom_range(0, 3));
      fifo_threshold = (AW+1)'($urandom_range(0, 16));
      wr_pct = $urandom_range(10, 90);
      en = 1;
      for (int c = 0; c < 200; c++) begin
        rst = ($urandom_range(0, 999) < 3);
        if ($urandom_range(0, 99) < 2) en = ~en;
        wr = ($urandom_range(0, 99) < wr_pct);
        wdata = DW'($urandom);
        status_clr = ($urandom_range(0, 99) < 3);
        flush = ($urandom_range(0, 99) < 1);
        step();
      end
    end
    rst = 0; en = 0; wr = 0; flush = 0; status_clr = 0;
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
